// File: rtl/mem_unit_if.sv
// rtl/mem_unit_if.sv - control-unit to memory-unit strobe and data bus interface
interface mem_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] bus_in;
    logic              mar_latch;
    logic              mar_inc;
    logic              mar_reset;
    logic              mem_read;
    logic              mem_write;
    logic              bus_sel_mem;
    logic [DATA_W-1:0] bus_out;
    logic              bus_out_en;
    logic [ADDR_W-1:0] mar_q;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;

    modport master (
        output bus_in, mar_latch, mar_inc, mar_reset, mem_read, mem_write, bus_sel_mem,
        input  bus_out, bus_out_en, mar_q, mem_busy, mem_done, mem_err
    );

    modport slave (
        input  bus_in, mar_latch, mar_inc, mar_reset, mem_read, mem_write, bus_sel_mem,
        output bus_out, bus_out_en, mar_q, mem_busy, mem_done, mem_err
    );
endinterface

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - MAR, RAM and wait-state access FSM answering control-unit memory strobes
module mem_unit #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    mem_unit_if.slave  bus
);
    localparam logic [3:0]      WS      = 4'(WAIT_STATES);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rdata;
    logic              acc_write;
    logic              acc_oob;
    logic              err;
    logic              out_en;
    logic              busy;
    logic              accept;
    logic              illegal;
    logic              mar_oob;
    logic [DATA_W-1:0] ram [DEPTH];

    assign busy    = (state != ST_IDLE);
    assign mar_oob = ({1'b0, mar} >= DEPTH_L);
    assign illegal = (busy & (bus.mem_read | bus.mem_write)) |
                     (~busy & bus.mem_read & bus.mem_write);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.mem_read ^ bus.mem_write) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = WS;
                    state_nxt    = (WS == 4'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            mar       <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_write <= 1'b0;
            acc_oob   <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            out_en    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;

            if (bus.mar_reset) begin
                mar <= '0;
            end else if (bus.mar_latch) begin
                mar <= bus.bus_in[ADDR_W-1:0];
            end else if (bus.mar_inc) begin
                mar <= mar + ADDR_W'(1);
            end

            // Address is frozen here so later MAR traffic cannot redirect the access.
            if (accept) begin
                acc_addr  <= mar;
                acc_wdata <= bus.bus_in;
                acc_write <= bus.mem_write;
                acc_oob   <= mar_oob;
            end

            if (state == ST_DONE && !acc_write) begin
                rdata <= acc_oob ? '0 : ram[acc_addr[IDX_W-1:0]];
            end

            if (illegal || (accept && mar_oob)) begin
                err <= 1'b1;
            end

            // Registered against the next-cycle busy so data read in DONE drives right after.
            out_en <= bus.bus_sel_mem & (state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && state == ST_DONE && acc_write && !acc_oob) begin
            ram[acc_addr[IDX_W-1:0]] <= acc_wdata;
        end
    end

    assign bus.bus_out    = rdata;
    assign bus.bus_out_en = out_en;
    assign bus.mar_q      = mar;
    assign bus.mem_busy   = busy;
    assign bus.mem_done   = (state == ST_DONE);
    assign bus.mem_err    = err;
endmodule
